// File: rtl/wb_crc_dma_pkg.sv
// Shared types and constants for the Wishbone CRC feeder DMA.
package wb_crc_dma_pkg;

  typedef enum logic [2:0] {
    IDLE, RD_SRC, GAP1, WR_CRC, GAP2, RD_RES, DONE, ERR
  } dma_state_e;

  localparam logic [2:0]  CTI_CLASSIC      = 3'b000;
  localparam logic [3:0]  SEL_ALL          = 4'hF;
  localparam logic [31:0] CRC_DATA_ADR_DEF = 32'h0000_0000;
  localparam logic [31:0] CRC_RES_ADR_DEF  = 32'h0008_0004;

endpackage

// File: rtl/wb_single_xfer.sv
// One classic Wishbone transfer with a bounded wait for ack/err.
module wb_single_xfer
  import wb_crc_dma_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] dat,
  output logic          ok,
  output logic          fail,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  // Last permitted stb cycle: stb is held for exactly TIMEOUT cycles without ack.
  assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
  assign ok        = wb_cyc_o & wb_ack_i & ~wb_err_i;
  assign fail      = wb_cyc_o & (wb_err_i | (~wb_ack_i & timed_out));
  assign rdata     = wb_dat_i;

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wait_cnt <= '0;
    end else if (!wb_cyc_o) begin
      if (req) begin
        wb_adr_o <= adr;
        wb_dat_o <= dat;
        wb_we_o  <= we;
        wb_sel_o <= SEL_ALL;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wait_cnt <= '0;
      end
    end else if (ok || fail) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_sel_o <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_crc_dma.sv
// Wishbone master that streams LEN words from memory into the CRC engine
// and latches the engine's result.
module wb_crc_dma
  import wb_crc_dma_pkg::*;
#(
  parameter int            AW           = 32,
  parameter int            DW           = 32,
  parameter int            LEN_W        = 16,
  parameter logic [AW-1:0] CRC_DATA_ADR = AW'(CRC_DATA_ADR_DEF),
  parameter logic [AW-1:0] CRC_RES_ADR  = AW'(CRC_RES_ADR_DEF),
  parameter int            TIMEOUT      = 255
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             start_i,
  input  logic [AW-1:0]    src_adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      crc_o,
  output logic [LEN_W-1:0] words_o,
  output logic [AW-1:0]    wb_adr_o,
  output logic [DW-1:0]    wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  dma_state_e       state;
  logic [AW-1:0]    ptr, start_ptr;
  logic [LEN_W-1:0] remaining;
  logic [DW-1:0]    word_q;

  logic             req, req_we, ok, fail;
  logic [AW-1:0]    req_adr;
  logic [DW-1:0]    rdata;

  assign start_ptr = src_adr_i & ~AW'(3);
  assign wb_cti_o  = CTI_CLASSIC;

  // Launch the next transfer on the edge that enters its bus state, so
  // cyc/stb come up together with the state and stay registered.
  always_comb begin
    req     = 1'b0;
    req_we  = 1'b0;
    req_adr = CRC_RES_ADR;
    case (state)
      IDLE: begin
        req = start_i;
        if (len_i != '0) req_adr = start_ptr;
      end
      GAP1: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = CRC_DATA_ADR;
      end
      GAP2: begin
        req = 1'b1;
        if (remaining != '0) req_adr = ptr;
      end
      default: ;
    endcase
  end

  wb_single_xfer #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) u_xfer (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .req     (req),
    .we      (req_we),
    .adr     (req_adr),
    .dat     (word_q),
    .ok      (ok),
    .fail    (fail),
    .rdata   (rdata),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o),
    .wb_we_o (wb_we_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      word_q    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      crc_o     <= '0;
      words_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          ptr       <= start_ptr;
          remaining <= len_i;
          err_o     <= 1'b0;
          words_o   <= '0;
          busy_o    <= 1'b1;
          state     <= (len_i != '0) ? RD_SRC : RD_RES;
        end
        RD_SRC: if (fail) begin
          state <= ERR; err_o <= 1'b1; done_o <= 1'b1; busy_o <= 1'b0;
        end else if (ok) begin
          word_q <= rdata;
          ptr    <= ptr + AW'(4);
          state  <= GAP1;
        end
        GAP1: state <= WR_CRC;
        WR_CRC: if (fail) begin
          state <= ERR; err_o <= 1'b1; done_o <= 1'b1; busy_o <= 1'b0;
        end else if (ok) begin
          words_o   <= words_o + LEN_W'(1);
          remaining <= remaining - LEN_W'(1);
          state     <= GAP2;
        end
        GAP2: state <= (remaining != '0) ? RD_SRC : RD_RES;
        RD_RES: if (fail) begin
          state <= ERR; err_o <= 1'b1; done_o <= 1'b1; busy_o <= 1'b0;
        end else if (ok) begin
          crc_o  <= rdata[31:0];
          state  <= DONE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
        // done_o/busy_o were set on entry; DONE and ERR just return home.
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_crc_dma.sv
// Directed bench for wb_crc_dma with a memory + CRC-32 engine slave model.
module tb_wb_crc_dma;

  localparam logic [31:0] RES_ADR = 32'h0008_0004;

  logic        wb_clk = 1'b0, wb_rst = 1'b0, start_i = 1'b0;
  logic [31:0] src_adr_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o, wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] crc_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [15:0] words_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i, wb_err_i;

  always #5 wb_clk = ~wb_clk;

  wb_crc_dma #(.AW(32), .DW(32), .LEN_W(16), .TIMEOUT(255)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start_i(start_i), .src_adr_i(src_adr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .crc_o(crc_o),
    .words_o(words_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  function automatic logic [31:0] crc32_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 32; i++) r = (r[0] ^ w[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Slave: memory for source reads, CRC engine at 0x0 (feed) / RES_ADR (result).
  logic [31:0] mem [0:255];
  logic [31:0] crc_state = 32'hFFFF_FFFF;
  logic        crc_clr = 1'b0, no_ack = 1'b0, ack_with_err = 1'b0;
  int          delay = 0, err_idx = -1, wcnt = 0;
  int          n_src = 0, n_wr = 0, n_res = 0, n_bad = 0, n_done = 0;
  logic        hit, src_rd;

  assign hit      = wb_cyc_o && wb_stb_o && !no_ack && (wcnt == delay);
  assign src_rd   = !wb_we_o && (wb_adr_o != RES_ADR);
  assign wb_err_i = hit && src_rd && (n_src == err_idx);
  assign wb_ack_i = hit && (!wb_err_i || ack_with_err);
  assign wb_dat_i = (wb_adr_o == RES_ADR) ? ~crc_state : mem[wb_adr_o[9:2]];

  always @(posedge wb_clk) begin
    if (crc_clr) crc_state <= 32'hFFFF_FFFF;
    if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
      wcnt <= 0;
      if (wb_we_o) begin
        n_wr <= n_wr + 1;
        if (wb_adr_o != 32'h0) n_bad <= n_bad + 1;
        else if (!wb_err_i) crc_state <= crc32_upd(crc_state, wb_dat_o);
      end else if (wb_adr_o == RES_ADR) n_res <= n_res + 1;
      else n_src <= n_src + 1;
    end else if (wb_cyc_o && wb_stb_o) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge wb_clk) if (done_o) n_done <= n_done + 1;

  int          n_vec = 0, n_miss = 0;
  logic [31:0] exp3, exp1;

  task automatic do_start(input logic [31:0] src, input logic [15:0] len);
    @(negedge wb_clk); src_adr_i = src; len_i = len; start_i = 1'b1;
    @(negedge wb_clk); start_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) if (done_o) seen = 1'b1; else @(negedge wb_clk);
  endtask

  task automatic clr_engine;
    @(negedge wb_clk); crc_clr = 1'b1;
    @(negedge wb_clk); crc_clr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge wb_clk);
    n_vec++; if ({wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_cti_o, busy_o, done_o, err_o, crc_o, words_o} !== '0) begin
      n_miss++; $display("FAIL reset_outputs: got nonzero cyc=%b busy=%b crc=%h words=%0d, want all 0", wb_cyc_o, busy_o, crc_o, words_o); end
    wb_rst = 1'b1;
  endtask

  task automatic test_basic;
    int s0, w0, r0, b0, d0; bit seen;
    delay = 2; clr_engine();
    s0 = n_src; w0 = n_wr; r0 = n_res; b0 = n_bad; d0 = n_done;
    do_start(32'h100, 16'd3);
    wait_done(200, seen);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL basic_done: no done within 200 cycles"); end
    repeat (2) @(negedge wb_clk); #1;
    n_vec++; if (n_src - s0 !== 3) begin n_miss++; $display("FAIL basic_src_reads: got %0d want 3", n_src - s0); end
    n_vec++; if (n_wr - w0 !== 3) begin n_miss++; $display("FAIL basic_crc_writes: got %0d want 3", n_wr - w0); end
    n_vec++; if (n_res - r0 !== 1) begin n_miss++; $display("FAIL basic_res_reads: got %0d want 1", n_res - r0); end
    n_vec++; if (n_bad !== b0) begin n_miss++; $display("FAIL basic_write_adr: %0d writes off 0x0", n_bad - b0); end
    n_vec++; if (crc_o !== exp3) begin n_miss++; $display("FAIL basic_crc: got %h want %h", crc_o, exp3); end
    n_vec++; if (words_o !== 16'd3) begin n_miss++; $display("FAIL basic_words: got %0d want 3", words_o); end
    n_vec++; if (err_o !== 1'b0) begin n_miss++; $display("FAIL basic_err: got %b want 0", err_o); end
    n_vec++; if (n_done - d0 !== 1) begin n_miss++; $display("FAIL basic_done_pulse: got %0d cycles want 1", n_done - d0); end
  endtask

  task automatic test_timing;
    logic [14:0] cyc_tr, done_tr, busy_tr;
    logic [31:0] a_rd, a_wr, d_wr;
    logic        we_rd, we_wr;
    delay = 0; clr_engine();
    @(negedge wb_clk); src_adr_i = 32'h102; len_i = 16'd3; start_i = 1'b1;
    cyc_tr[0] = wb_cyc_o; done_tr[0] = done_o; busy_tr[0] = busy_o;
    a_rd = '0; a_wr = '1; d_wr = '0; we_rd = 1'b1; we_wr = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(negedge wb_clk);
      if (i == 1) begin start_i = 1'b0; a_rd = wb_adr_o; we_rd = wb_we_o; end
      if (i == 3) begin a_wr = wb_adr_o; we_wr = wb_we_o; d_wr = wb_dat_o; end
      cyc_tr[i] = wb_cyc_o; done_tr[i] = done_o; busy_tr[i] = busy_o;
    end
    n_vec++; if (cyc_tr !== 15'h2AAA) begin n_miss++; $display("FAIL timing_cyc_trace: got %h want 2aaa", cyc_tr); end
    n_vec++; if (done_tr !== 15'h4000) begin n_miss++; $display("FAIL timing_done_trace: got %h want 4000", done_tr); end
    n_vec++; if (busy_tr !== 15'h3FFE) begin n_miss++; $display("FAIL timing_busy_trace: got %h want 3ffe", busy_tr); end
    n_vec++; if ({we_rd, a_rd} !== {1'b0, 32'h100}) begin n_miss++; $display("FAIL timing_first_read: got we=%b adr=%h want we=0 adr=00000100", we_rd, a_rd); end
    n_vec++; if ({we_wr, a_wr, d_wr} !== {1'b1, 32'h0, 32'h0101_0101}) begin n_miss++; $display("FAIL timing_first_write: got we=%b adr=%h dat=%h want 1/0/01010101", we_wr, a_wr, d_wr); end
    @(negedge wb_clk);
    n_vec++; if (crc_o !== exp3) begin n_miss++; $display("FAIL timing_crc: got %h want %h", crc_o, exp3); end
  endtask

  task automatic test_error;
    int w0; bit seen;
    delay = 0; ack_with_err = 1'b1; clr_engine();
    w0 = n_wr; err_idx = n_src + 1;
    do_start(32'h100, 16'd4);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) if (wb_err_i) seen = 1'b1; else @(negedge wb_clk);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL err_seen: second source read never reached"); end
    @(negedge wb_clk);
    n_vec++; if (wb_cyc_o !== 1'b0) begin n_miss++; $display("FAIL err_cyc_drop: got cyc=%b want 0", wb_cyc_o); end
    n_vec++; if ({err_o, done_o} !== 2'b11) begin n_miss++; $display("FAIL err_flags: got err=%b done=%b want 1 1", err_o, done_o); end
    @(negedge wb_clk); #1;
    n_vec++; if ({busy_o, done_o, err_o} !== 3'b001) begin n_miss++; $display("FAIL err_after: got busy=%b done=%b err=%b want 0 0 1", busy_o, done_o, err_o); end
    n_vec++; if (words_o !== 16'd1) begin n_miss++; $display("FAIL err_words: got %0d want 1", words_o); end
    n_vec++; if (crc_o !== exp3) begin n_miss++; $display("FAIL err_crc_kept: got %h want %h", crc_o, exp3); end
    n_vec++; if (n_wr - w0 !== 1) begin n_miss++; $display("FAIL err_writes: got %0d want 1", n_wr - w0); end
    err_idx = -1; ack_with_err = 1'b0;
  endtask

  task automatic test_len0;
    int s0, w0, r0; bit seen;
    s0 = n_src; w0 = n_wr; r0 = n_res;
    do_start(32'h100, 16'd0);
    wait_done(20, seen);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL len0_done: no done within 20 cycles"); end
    @(negedge wb_clk); #1;
    n_vec++; if ({n_src - s0, n_wr - w0, n_res - r0} !== {32'd0, 32'd0, 32'd1}) begin n_miss++; $display("FAIL len0_traffic: got src=%0d wr=%0d res=%0d want 0 0 1", n_src - s0, n_wr - w0, n_res - r0); end
    n_vec++; if (crc_o !== exp1) begin n_miss++; $display("FAIL len0_crc: got %h want %h", crc_o, exp1); end
    n_vec++; if ({words_o, err_o} !== {16'd0, 1'b0}) begin n_miss++; $display("FAIL len0_words_err: got words=%0d err=%b want 0 0", words_o, err_o); end
  endtask

  task automatic test_timeout;
    int cnt; bit seen;
    delay = 254;
    do_start(32'h100, 16'd0);
    wait_done(300, seen);
    n_vec++; if (!seen || err_o !== 1'b0) begin n_miss++; $display("FAIL timeout_edge_ack: seen=%b err=%b want 1 0", seen, err_o); end
    delay = 0; no_ack = 1'b1;
    do_start(32'h100, 16'd2);
    cnt = 0;
    while (wb_stb_o && cnt < 400) begin cnt++; @(negedge wb_clk); end
    n_vec++; if (cnt !== 255) begin n_miss++; $display("FAIL timeout_stb_cycles: got %0d want 255", cnt); end
    n_vec++; if ({err_o, done_o} !== 2'b11) begin n_miss++; $display("FAIL timeout_flags: got err=%b done=%b want 1 1", err_o, done_o); end
    @(negedge wb_clk);
    n_vec++; if ({busy_o, done_o, wb_cyc_o} !== 3'b000) begin n_miss++; $display("FAIL timeout_after: got busy=%b done=%b cyc=%b want 0", busy_o, done_o, wb_cyc_o); end
    n_vec++; if ({words_o, crc_o} !== {16'd0, exp1}) begin n_miss++; $display("FAIL timeout_state: got words=%0d crc=%h want 0 %h", words_o, crc_o, exp1); end
    no_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    int s0, d0; bit seen;
    delay = 0; clr_engine();
    s0 = n_src;
    do_start(32'h100, 16'd3);
    repeat (3) @(negedge wb_clk);
    src_adr_i = 32'h200; len_i = 16'd1; start_i = 1'b1;
    @(negedge wb_clk); start_i = 1'b0;
    wait_done(100, seen);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL b2b_done: no done within 100 cycles"); end
    src_adr_i = 32'h100; len_i = 16'd2; start_i = 1'b1;
    @(negedge wb_clk); start_i = 1'b0;
    n_vec++; if ({busy_o, wb_cyc_o} !== 2'b00) begin n_miss++; $display("FAIL b2b_start_in_done: got busy=%b cyc=%b want 0 0", busy_o, wb_cyc_o); end
    #1;
    n_vec++; if ({words_o, crc_o} !== {16'd3, exp3} || n_src - s0 !== 3) begin n_miss++; $display("FAIL b2b_run: got words=%0d crc=%h reads=%0d want 3 %h 3", words_o, crc_o, n_src - s0, exp3); end
    // Reset in the middle of a CRC write, then a clean run.
    do_start(32'h100, 16'd3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) if (wb_cyc_o && wb_we_o) seen = 1'b1; else @(negedge wb_clk);
    n_vec++; if (!seen) begin n_miss++; $display("FAIL rst_reach_wr: no CRC write seen"); end
    #1 wb_rst = 1'b0;
    #1;
    n_vec++; if ({wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_cti_o, busy_o, done_o, err_o, crc_o, words_o} !== '0) begin
      n_miss++; $display("FAIL rst_async_clear: got cyc=%b busy=%b crc=%h words=%0d want all 0", wb_cyc_o, busy_o, crc_o, words_o); end
    d0 = n_done;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b1;
    repeat (3) @(negedge wb_clk); #1;
    n_vec++; if (n_done !== d0 || busy_o !== 1'b0) begin n_miss++; $display("FAIL rst_no_done: got done_cycles=%0d busy=%b want 0 0", n_done - d0, busy_o); end
    clr_engine();
    do_start(32'h100, 16'd3);
    wait_done(100, seen);
    @(negedge wb_clk);
    n_vec++; if (!seen || {words_o, err_o, crc_o} !== {16'd3, 1'b0, exp3}) begin n_miss++; $display("FAIL rst_rerun: got seen=%b words=%0d err=%b crc=%h want 1 3 0 %h", seen, words_o, err_o, crc_o, exp3); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[64] = 32'h0101_0101; mem[65] = 32'h0202_0202;
    mem[66] = 32'h0404_0404; mem[67] = 32'h0808_0808;
    exp1 = ~crc32_upd(32'hFFFF_FFFF, 32'h0101_0101);
    exp3 = ~crc32_upd(crc32_upd(crc32_upd(32'hFFFF_FFFF, 32'h0101_0101), 32'h0202_0202), 32'h0404_0404);
    test_reset();
    test_basic();
    test_timing();
    test_error();
    test_len0();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_crc_dma.md
Name: wb_crc_dma

Overview:
Wishbone classic master that sits directly upstream of the wb_crc32 slave and feeds it. On a start pulse it reads LEN words from memory, starting at SRC_ADR. Each word read is written to the CRC data register. After the last word it reads the CRC result register and latches the value for firmware or the SD write path. It replaces CPU-driven word-by-word CRC feeding.

Parameters:
AW, 32, Wishbone address width
DW, 32, Wishbone data width (only 32 supported)
LEN_W, 16, width of the word-count input
CRC_DATA_ADR, 32'h0000_0000, address of the CRC data (feed) register
CRC_RES_ADR, 32'h0008_0004, address of the CRC result register
TIMEOUT, 255, maximum cycles stb may wait for ack/err before the transfer aborts

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle start request; sampled only in IDLE
src_adr_i  in  AW  byte address of first source word; bits [1:0] ignored
len_i  in  LEN_W  number of 32-bit words to process
busy_o  out  1  high from the cycle after start is accepted until DONE/ERR completes
done_o  out  1  one-cycle pulse at the end of every run (success or error)
err_o  out  1  sticky error flag of the last run; cleared on next accepted start
crc_o  out  32  CRC result of the last successful run
words_o  out  LEN_W  words written to CRC engine in current/last run
wb_adr_o  out  AW  master address
wb_dat_o  out  DW  master write data
wb_sel_o  out  4  always 4'hF during a cycle
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  always 3'b000 (classic)
wb_dat_i  in  DW  read data
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  bus error

Behaviour:
- Reset (wb_rst=0, async): state IDLE; all outputs 0 (adr, dat, we, cyc, stb, sel, cti, busy, done, err, crc, words). Reset mid-run drops cyc/stb immediately; no completion pulse.
- All outputs registered. Single classic transfers only. cyc=stb for every transfer.
- States:
  - IDLE: on start_i, latch ptr = {src_adr_i[AW-1:2],2'b00} and remaining = len_i; clear err_o and words_o; set busy_o. Go to RD_SRC if len_i != 0, else RD_RES.
  - RD_SRC: assert cyc/stb, we=0, adr=ptr. On ack: latch wb_dat_i, ptr += 4, then GAP1.
  - GAP1: cyc=stb=0 for exactly one cycle, then WR_CRC.
  - WR_CRC: assert cyc/stb, we=1, adr=CRC_DATA_ADR, dat=latched word. On ack: words_o += 1, remaining -= 1, then GAP2.
  - GAP2: one idle cycle. Go to RD_SRC if remaining != 0, else RD_RES.
  - RD_RES: we=0, adr=CRC_RES_ADR. On ack: crc_o <= wb_dat_i, then DONE.
  - DONE: done_o=1 for one cycle, busy_o=0, then IDLE.
  - ERR: err_o=1, done_o=1 for one cycle, busy_o=0, crc_o unchanged, then IDLE.
- Each bus state has a wait counter, cleared on entry. If wb_err_i is seen, or the counter reaches TIMEOUT with no ack, drop cyc/stb on the next edge and go to ERR.
- If ack and err arrive in the same cycle, err wins.
- start_i while busy is ignored. start_i in the cycle DONE/ERR returns to IDLE is also ignored; it is only sampled in IDLE.
- ptr wraps modulo 2^AW with no error.
- With a slave that acks in the first stb cycle, each word costs 4 cycles; a run of N words costs 4N + 3 cycles from start to done (start, RD_RES, DONE).
- len_i=0: no source or feed traffic. The result register is read, giving the CRC engine's current value.

Decomposition:
- Package wb_crc_dma_pkg: state enum (IDLE, RD_SRC, GAP1, WR_CRC, GAP2, RD_RES, DONE, ERR), CTI_CLASSIC = 3'b000, SEL_ALL = 4'hF, default CRC register addresses.
- Sub-module wb_single_xfer: one classic Wishbone transaction with the timeout counter. Inputs: req, we, adr, dat. Outputs: ok, fail, rdata. The FSM instantiates it once and muxes the request fields.

Test Plan:
- Memory model with 0x01010101, 0x02020202, 0x04040404 at 0x100; wb_crc32 as slave; start src=0x100 len=3 -> exactly 3 reads, 3 writes to 0x0, 1 read of 0x80004; crc_o equals software CRC-32 of the 3 words; words_o=3; done single pulse; err_o=0.
- Same run with zero-wait slave -> done asserted exactly 15 cycles after start accepted; exactly one idle cycle (cyc=0) between transfers.
- len=0 -> only one read at 0x80004; crc_o equals engine's current value; words_o=0.
- wb_err_i on second source read (len=4) -> cyc drops next cycle; err_o=1; done pulse; words_o=1; crc_o keeps its prior value.
- Slave never acks, TIMEOUT=255 -> stb held 255 cycles, then ERR/done; busy_o low afterwards.
- start_i pulsed mid-run, and wb_rst asserted mid-WR_CRC -> second start has no effect; reset clears all outputs asynchronously; a new run after reset completes correctly.
